// File: rtl/reg_1_if.sv
// Bus bundle for the reg_1 storage cell: the per-edge controls, the data in, and the true and complemented outputs.
interface reg_1_if #(
    parameter int WIDTH = 1
);
    logic             P;
    logic             L;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Qbar;

    modport master (
        output P,
        output L,
        output D,
        input  Q,
        input  Qbar
    );

    modport slave (
        input  P,
        input  L,
        input  D,
        output Q,
        output Qbar
    );
endinterface

// File: rtl/reg_1.sv
// Edge-triggered storage register, WIDTH bits wide, with synchronous reset, preset and load enable.
// Qbar is driven as the complement of the stored value, so Q and Qbar can never be equal.
module reg_1 #(
    parameter int WIDTH = 1
) (
    input  logic   C,
    input  logic   R,
    reg_1_if.slave bus
);
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Preset has priority over load. Reset has priority over both and is applied in the flop process.
    always_comb begin
        q_d = q_q;
        if (bus.P) begin
            q_d = '1;
        end else if (bus.L) begin
            q_d = bus.D;
        end
    end

    always_ff @(posedge C) begin
        if (R) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign bus.Q    = q_q;
    assign bus.Qbar = ~q_q;
endmodule

// File: tb/tb_reg_1.sv
// Scoreboard bench for reg_1: one 1-bit instance and one 8-bit instance share the controls.
module tb_reg_1;
    logic C;
    logic R;

    reg_1_if #(.WIDTH(1)) bus1 ();
    reg_1_if #(.WIDTH(8)) bus8 ();

    reg_1 #(.WIDTH(1)) dut1 (.C(C), .R(R), .bus(bus1));
    reg_1 #(.WIDTH(8)) dut8 (.C(C), .R(R), .bus(bus8));

    typedef struct {
        logic       q1;
        logic [7:0] q8;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_e;
    bit   have_last = 0;
    int   checks    = 0;
    int   failures  = 0;

    // Reference state for the expected value of each register.
    logic       m1;
    logic [7:0] m8;

    initial C = 1'b0;
    always #5 C = ~C;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h time=%0t", name, act, req, $time);
        end
    endtask

    // Returns the value the register holds after an edge, given the controls sampled at that edge.
    function automatic logic [7:0] after_edge(input logic r, input logic p, input logic l,
                                              input logic [7:0] d, input logic [7:0] q,
                                              input logic [7:0] ones);
        if (r)      return 8'h00;
        else if (p) return ones;
        else if (l) return d;
        else        return q;
    endfunction

    // Called on a falling edge (or at time 0). Drives one edge's worth of stimulus and
    // pushes what both registers must hold after the following rising edge.
    task automatic step(input logic r, input logic p, input logic l,
                        input logic d1, input logic [7:0] d8, input bit glitch);
        exp_t e;
        R      = r;
        bus1.P = p;
        bus8.P = p;
        bus1.L = l;
        bus8.L = l;
        if (glitch) begin
            bus1.D = ~d1;
            bus8.D = ~d8;
            #2;
        end
        bus1.D = d1;
        bus8.D = d8;
        m1   = after_edge(r, p, l, {7'b0, d1}, {7'b0, m1}, 8'h01) != 0;
        m8   = after_edge(r, p, l, d8, m8, 8'hFF);
        e.q1 = m1;
        e.q8 = m8;
        exp_q.push_back(e);
        @(negedge C);
    endtask

    // Monitor: after every rising edge, compare against the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge C);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("q1",    {7'b0, bus1.Q},    {7'b0, e.q1});
                chk("qbar1", {7'b0, bus1.Qbar}, {7'b0, ~e.q1});
                chk("q8",    bus8.Q,            e.q8);
                chk("qbar8", bus8.Qbar,         ~e.q8);
                last_e    = e;
                have_last = 1;
            end
        end
    end

    // Just before each rising edge the outputs must still hold the last stored value,
    // even though the controls and data changed earlier in the cycle.
    initial begin
        forever begin
            @(negedge C);
            #4;
            if (have_last) begin
                chk("hold1_pre_edge", {7'b0, bus1.Q}, {7'b0, last_e.q1});
                chk("hold8_pre_edge", bus8.Q,         last_e.q8);
            end
        end
    end

    initial begin
        logic r, p, l;
        int   guard;
        m1 = 1'b0;
        m8 = 8'h00;

        // Reset over the 5 ns edge, then retention.
        step(1, 0, 0, 1, 8'hFF, 0);
        step(0, 0, 0, 1, 8'hFF, 0);
        step(0, 0, 0, 1, 8'h3C, 0);
        // Reset and preset together, then preset alone, then hold.
        step(1, 1, 0, 1, 8'hFF, 0);
        step(0, 1, 0, 0, 8'h00, 0);
        step(0, 0, 0, 0, 8'h00, 0);
        step(1, 0, 0, 0, 8'h00, 0);
        // Load sequence with glitchy data between edges.
        step(0, 0, 1, 1, 8'h81, 0);
        step(0, 0, 1, 1, 8'h42, 0);
        step(0, 0, 1, 0, 8'h24, 1);
        step(0, 0, 1, 1, 8'h18, 1);
        step(0, 0, 1, 0, 8'h00, 1);
        // Hold with data toggling mid-cycle.
        step(0, 0, 1, 1, 8'h5A, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, i[0], 8'(i * 37), 1);
        // Reset during load, then release.
        step(1, 0, 1, 1, 8'h77, 0);
        step(0, 0, 1, 1, 8'h77, 0);
        // Width: load A5, preset, reset.
        step(0, 0, 1, 0, 8'hA5, 0);
        step(0, 1, 0, 0, 8'h00, 0);
        step(1, 0, 0, 1, 8'hFF, 0);

        // Randomised traffic with weighted controls.
        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(0, 9) == 0);
            p = ($urandom_range(0, 7) == 0);
            l = ($urandom_range(0, 1) == 1);
            step(r, p, l, 1'($urandom), 8'($urandom), bit'($urandom_range(0, 1)));
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge C);
            #2;
            guard++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
